euler_result_tx: RTL and testbench
==================================

# euler_result_tx

Result-side transmitter for the Euler solver blocks. It watches a solver's `result`/`done`/`error` outputs. On each new completion it converts the binary result to unsigned ASCII decimal, with no leading zeros and a trailing LF. It streams the characters one byte at a time over a valid/ready interface to the board's UART or console FIFO. A solver error produces the fixed string "ERR" + LF instead.

## Interface
- `WIDTH`, 46: width of the solver result, in bits.
- `DIGITS`, 14: BCD digit count. Must satisfy 10^DIGITS > 2^WIDTH − 1.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_result`  in  WIDTH  solver result; sampled only in the capture cycle.
- `in_done`  in  1  solver completion, level.
- `in_error`  in  1  solver error flag; sampled together with `in_result`.
- `out_data`  out  8  ASCII byte.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  sink accepts the byte when `out_valid && out_ready`.
- `busy`  out  1  high from the capture cycle until the LF is accepted.
- `sent`  out  1  one-cycle pulse in the cycle after the LF handshake.

## Operation
- States: IDLE, CONVERT, LOCATE, SEND, WAIT_LOW.
- IDLE
  - Fires when `in_done` = 1 and the `armed` flag = 1.
  - On firing: captures `in_result` into a shift register and `in_error` into `err_q`, clears the BCD register, clears `armed`, sets `busy`.
  - If `err_q` = 1, goes straight to SEND using the error string. Otherwise goes to CONVERT.
- CONVERT
  - Iterative double-dabble, exactly WIDTH cycles.
  - Each cycle: add 3 to every BCD nibble ≥ 5, then shift {bcd, bin} left by 1.
  - BCD register is 4·DIGITS bits wide; no overflow is possible under the parameter rule.
- LOCATE: one cycle. A priority encoder finds the most-significant nonzero nibble. If all nibbles are zero, it selects nibble 0, so the value 0 prints as "0".
- SEND
  - Digit byte = 8'h30 + nibble, emitted MSB nibble first down to nibble 0, then 8'h0A.
  - Error string is 8'h45, 8'h52, 8'h52, 8'h0A.
  - Index advances only on a handshake.
  - Handshake on the LF: clear `busy`, pulse `sent`, go to WAIT_LOW.
- WAIT_LOW: waits for `in_done` = 0, then sets `armed` and returns to IDLE.
- Net effect: a level-held `in_done` transmits exactly once. A new solver run must drop `in_done` first.
- Changes on `in_result`/`in_error` after capture are ignored.

## Timing
- Reset values
  - `out_data` = 0, `out_valid` = 0, `busy` = 0, `sent` = 0.
  - State IDLE, `armed` = 1, BCD = 0.
- `rst_n` low at any time, including mid-CONVERT or mid-SEND, returns to reset values immediately. A partially sent line is abandoned, not resumed.
- Capture happens at edge E0 where IDLE samples `in_done` = 1.
- Number path
  - CONVERT occupies edges E1..E_WIDTH; LOCATE occupies E_WIDTH+1.
  - `out_valid` is first high after edge E_WIDTH+2.
  - `busy` is high after E0.
- Error path: `out_valid` is high after E1.
- Output register rules
  - `out_data` is registered.
  - While `out_valid && !out_ready`, `out_data` and `out_valid` hold stable.
  - With `out_ready` held high, one byte is accepted per cycle with no bubbles; the next byte is presented in the cycle after each handshake.
  - `out_valid` is never high outside SEND.
- Byte-count bound
  - `out_valid` is low in the cycle after the LF handshake; `sent` is high in that same cycle.
  - A number line is at most DIGITS+1 bytes; an error line is exactly 4 bytes.
- If `in_done` falls during CONVERT or SEND, the transmission still completes. WAIT_LOW then exits on the next cycle.

## Structure
- Shared package `euler_pkg`:
  - State enum `tx_state_t`.
  - ASCII constants: ZERO = 8'h30, LF = 8'h0A, 'E', 'R'.
  - Default `WIDTH`/`DIGITS` localparams reused by the solvers.
- One sub-module: `bin2bcd_iter`.
  - Parameterised WIDTH/DIGITS.
  - Ports: start, busy/done, bcd out. Runs the WIDTH-cycle double-dabble.
- The top block holds the FSM, the LOCATE encoder and the byte mux.

## Test plan
- `in_result` = 23514624000, `in_done` rises, `out_ready` = 1 → bytes "23514624000" + 8'h0A (12 bytes). First `out_valid` after E48. `sent` pulses once.
- `in_result` = 0 → "0" + LF (2 bytes); no extra zeros.
- `in_result` = 2^46−1 → "70368744177663" + LF (15 bytes).
- `in_error` = 1 with `in_result` = 12345 → "ERR" + LF only. `out_valid` high after E1.
- `in_result` = 907, with `out_ready` toggled pseudo-randomly and held low for 5 cycles mid-line → `out_data` stable while stalled; exact byte order "907" + LF. Then `in_done` held high for 100 more cycles → no second line. Drop and re-raise `in_done` → line repeats.
- Assert `rst_n` low during SEND after 3 bytes → outputs return to reset values at once. `in_done` high after release → full line restarts from the first digit.

Source files
------------

// File: rtl/euler_pkg.sv
// Shared definitions for the Euler solver result path: transmitter states,
// ASCII constants and the default solver result sizing.
package euler_pkg;

   localparam int DEFAULT_WIDTH  = 46;
   localparam int DEFAULT_DIGITS = 14;

   typedef enum logic [2:0] {
      IDLE,
      CONVERT,
      LOCATE,
      SEND,
      WAIT_LOW
   } tx_state_t;

   localparam logic [7:0] ASCII_ZERO = 8'h30;
   localparam logic [7:0] ASCII_LF   = 8'h0A;
   localparam logic [7:0] ASCII_E    = 8'h45;
   localparam logic [7:0] ASCII_R    = 8'h52;

endpackage

// File: rtl/bin2bcd_iter.sv
// Iterative double-dabble converter: loads on start, then performs one
// add-3/shift step per cycle for exactly WIDTH cycles.
module bin2bcd_iter #(
   parameter int WIDTH  = 46,
   parameter int DIGITS = 14
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_i,
   input  logic [WIDTH-1:0]      bin_i,
   output logic                  done_o,
   output logic [4*DIGITS-1:0]   bcd_o
);

   localparam int CNTW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0]    bin_q;
   logic [4*DIGITS-1:0] bcd_q;
   logic [4*DIGITS-1:0] bcdAdj_d;
   logic [CNTW-1:0]     cnt_q;
   logic                busy_q;

   always_comb begin
      bcdAdj_d = bcd_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) begin
            bcdAdj_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bin_q  <= '0;
         bcd_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else if (start_i) begin
         bin_q  <= bin_i;
         bcd_q  <= '0;
         cnt_q  <= CNTW'(WIDTH);
         busy_q <= 1'b1;
      end else if (busy_q) begin
         {bcd_q, bin_q} <= {bcdAdj_d, bin_q} << 1;
         cnt_q          <= cnt_q - 1'b1;
         if (cnt_q == CNTW'(1)) begin
            busy_q <= 1'b0;
         end
      end
   end

   // High during the cycle whose closing edge performs the final shift.
   assign done_o = busy_q && (cnt_q == CNTW'(1));
   assign bcd_o  = bcd_q;

endmodule

// File: rtl/euler_result_tx.sv
// Streams a solver result as ASCII decimal + LF (or "ERR" + LF) over a
// valid/ready byte interface, once per rising solver completion.
module euler_result_tx
   import euler_pkg::*;
#(
   parameter int WIDTH  = DEFAULT_WIDTH,
   parameter int DIGITS = DEFAULT_DIGITS
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_result,
   input  logic             in_done,
   input  logic             in_error,
   output logic [7:0]       out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic             sent
);

   localparam int POSW = $clog2(DIGITS + 2);
   localparam int NIBW = $clog2(DIGITS + 1);

   tx_state_t           state_q;
   logic                armed_q;
   logic                err_q;
   logic                busy_q;
   logic                sent_q;
   logic                outValid_q;
   logic [7:0]          outData_q;
   logic [POSW-1:0]     pos_q;
   logic [NIBW-1:0]     msb_q;
   logic [NIBW-1:0]     msb_d;
   logic                fire;
   logic                convStart;
   logic                convDone;
   logic [4*DIGITS-1:0] bcd;

   assign fire      = (state_q == IDLE) && in_done && armed_q;
   assign convStart = fire && !in_error;

   bin2bcd_iter #(
      .WIDTH  (WIDTH),
      .DIGITS (DIGITS)
   ) u_bin2bcd (
      .clk     (clk),
      .rst_n   (rst_n),
      .start_i (convStart),
      .bin_i   (in_result),
      .done_o  (convDone),
      .bcd_o   (bcd)
   );

   // Highest nonzero nibble wins; an all-zero value falls back to nibble 0.
   always_comb begin
      msb_d = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd[4*i +: 4] != 4'd0) begin
            msb_d = NIBW'(i);
         end
      end
   end

   function automatic logic [7:0] byteAt(input logic [POSW-1:0] p);
      logic [7:0] b;
      int         nib;
      b   = ASCII_LF;
      nib = 0;
      if (err_q) begin
         case (p)
            POSW'(0): b = ASCII_E;
            POSW'(1): b = ASCII_R;
            POSW'(2): b = ASCII_R;
            default:  b = ASCII_LF;
         endcase
      end else if (int'(p) <= int'(msb_q)) begin
         nib = int'(msb_q) - int'(p);
         b   = ASCII_ZERO + {4'b0000, 4'(bcd >> (4 * nib))};
      end
      return b;
   endfunction

   // Byte position counts up from the first character; the line ends when
   // the LF currently presented is accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         armed_q    <= 1'b1;
         err_q      <= 1'b0;
         busy_q     <= 1'b0;
         sent_q     <= 1'b0;
         outValid_q <= 1'b0;
         outData_q  <= '0;
         pos_q      <= '0;
         msb_q      <= '0;
      end else begin
         sent_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (fire) begin
                  err_q   <= in_error;
                  armed_q <= 1'b0;
                  busy_q  <= 1'b1;
                  pos_q   <= '0;
                  state_q <= in_error ? SEND : CONVERT;
               end
            end
            CONVERT: begin
               if (convDone) begin
                  state_q <= LOCATE;
               end
            end
            LOCATE: begin
               msb_q   <= msb_d;
               pos_q   <= '0;
               state_q <= SEND;
            end
            SEND: begin
               if (!outValid_q) begin
                  outData_q  <= byteAt(pos_q);
                  outValid_q <= 1'b1;
               end else if (out_ready) begin
                  if (outData_q == ASCII_LF) begin
                     outValid_q <= 1'b0;
                     outData_q  <= '0;
                     busy_q     <= 1'b0;
                     sent_q     <= 1'b1;
                     state_q    <= WAIT_LOW;
                  end else begin
                     pos_q     <= pos_q + 1'b1;
                     outData_q <= byteAt(pos_q + 1'b1);
                  end
               end
            end
            WAIT_LOW: begin
               if (!in_done) begin
                  armed_q <= 1'b1;
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign out_data  = outData_q;
   assign out_valid = outValid_q;
   assign busy      = busy_q;
   assign sent      = sent_q;

endmodule

// File: tb/tb_euler_result_tx.sv
// Scoreboard bench for euler_result_tx: expected bytes are queued by the
// stimulus and popped by a monitor on every accepted byte.
module tb_euler_result_tx;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [45:0] in_result = '0;
   logic        in_done = 1'b0;
   logic        in_error = 1'b0;
   logic        out_ready = 1'b1;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        busy;
   logic        sent;

   int          compared = 0;
   int          mismatched = 0;
   logic [7:0]  expQ[$];
   int          hsCount = 0;
   int          sentCount = 0;
   int          sentBase = 0;
   logic        prevStall = 1'b0;
   logic [7:0]  prevData = '0;

   euler_result_tx #(
      .WIDTH  (46),
      .DIGITS (14)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_result (in_result),
      .in_done   (in_done),
      .in_error  (in_error),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy),
      .sent      (sent)
   );

   always #5 clk = ~clk;

   initial begin
      #200us;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // Monitor: compares accepted bytes against the queue, checks stall hold
   // and that the valid line is idle in the cycle of the sent pulse.
   always @(negedge clk) begin
      if (!rst_n) begin
         prevStall = 1'b0;
      end else begin
         if (prevStall) begin
            checkOutput("stall_valid_hold", {63'd0, out_valid}, 64'd1);
            checkOutput("stall_data_hold", {56'd0, out_data}, {56'd0, prevData});
         end
         if (out_valid && out_ready) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected_byte", {56'd0, out_data}, 64'hFFFF);
            end else begin
               checkOutput("byte", {56'd0, out_data}, {56'd0, expQ.pop_front()});
            end
            hsCount++;
         end
         if (sent) begin
            sentCount++;
            checkOutput("valid_low_with_sent", {63'd0, out_valid}, 64'd0);
         end
         prevStall = out_valid && !out_ready;
         prevData  = out_data;
      end
   end

   task automatic pushLine(input string s);
      for (int i = 0; i < s.len(); i++) begin
         expQ.push_back(s[i]);
      end
      expQ.push_back(8'h0A);
   endtask

   task automatic waitValid(input int expLat);
      int cyc;
      cyc = 0;
      while (cyc < 200) begin
         @(negedge clk);
         if (out_valid) break;
         @(posedge clk);
         cyc++;
      end
      checkOutput("first_valid_latency", 64'(cyc), 64'(expLat));
   endtask

   task automatic applyStimulus(input logic [45:0] val, input logic err, input string line, input int expLat);
      pushLine(line);
      @(posedge clk); #1;
      sentBase  = sentCount;
      in_result = val;
      in_error  = err;
      in_done   = 1'b1;
      @(posedge clk); #1;
      checkOutput("busy_after_capture", {63'd0, busy}, 64'd1);
      in_result = ~val;
      in_error  = ~err;
      waitValid(expLat);
   endtask

   task automatic finishLine(input logic stall);
      logic [12:0] pat;
      int          cyc;
      pat = 13'b1101100000101;
      if (stall) begin
         @(posedge clk); #1;
         for (int i = 0; i < 13; i++) begin
            out_ready = pat[i];
            @(posedge clk); #1;
         end
         out_ready = 1'b1;
      end
      cyc = 0;
      while (sentCount == sentBase && cyc < 400) begin
         @(posedge clk); #1;
         cyc++;
      end
      repeat (2) @(posedge clk);
      #1;
      checkOutput("sent_pulse_count", 64'(sentCount), 64'(sentBase + 1));
      checkOutput("queue_drained", 64'(expQ.size()), 64'd0);
      checkOutput("busy_after_line", {63'd0, busy}, 64'd0);
      in_error  = 1'b0;
      in_result = '0;
   endtask

   task automatic dropDone();
      in_done = 1'b0;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic checkResetValues();
      checkOutput("reset_out_data", {56'd0, out_data}, 64'd0);
      checkOutput("reset_out_valid", {63'd0, out_valid}, 64'd0);
      checkOutput("reset_busy", {63'd0, busy}, 64'd0);
      checkOutput("reset_sent", {63'd0, sent}, 64'd0);
   endtask

   task automatic resetMidLine();
      int base;
      int cyc;
      base = hsCount;
      out_ready = 1'b1;
      applyStimulus(46'd23514624000, 1'b0, "23514624000", 48);
      cyc = 0;
      while (hsCount < base + 3 && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
      end
      checkOutput("handshakes_before_reset", 64'(hsCount - base), 64'd3);
      rst_n = 1'b0;
      #1;
      checkResetValues();
      expQ.delete();
      pushLine("23514624000");
      in_result = 46'd23514624000;
      in_error  = 1'b0;
      @(posedge clk); #1;
      sentBase = sentCount;
      rst_n = 1'b1;
      @(posedge clk); #1;
      checkOutput("busy_after_restart", {63'd0, busy}, 64'd1);
      waitValid(48);
      finishLine(1'b0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      checkResetValues();
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      applyStimulus(46'd23514624000, 1'b0, "23514624000", 48);
      finishLine(1'b0);
      dropDone();

      applyStimulus(46'd0, 1'b0, "0", 48);
      finishLine(1'b0);
      dropDone();

      applyStimulus(46'h3FFF_FFFF_FFFF, 1'b0, "70368744177663", 48);
      finishLine(1'b0);
      dropDone();

      applyStimulus(46'd12345, 1'b1, "ERR", 1);
      finishLine(1'b0);
      dropDone();

      out_ready = 1'b0;
      applyStimulus(46'd907, 1'b0, "907", 48);
      finishLine(1'b1);
      repeat (100) @(posedge clk);
      #1;
      checkOutput("no_retrigger_while_held", 64'(sentCount), 64'(sentBase + 1));
      dropDone();

      out_ready = 1'b0;
      applyStimulus(46'd907, 1'b0, "907", 48);
      finishLine(1'b1);
      dropDone();

      resetMidLine();
      dropDone();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
